// File: rtl/sampler_capture_ctrl.sv
// sampler_capture_ctrl: run sequencer that arms a capture, clears the sampler, waits for a masked trigger, captures and drains
//   clk, rst            clock and synchronous active-high reset
//   i_start, i_abort    one-cycle run start / stop pulses
//   i_trig_mask/value   masked pattern compared against i_s every cycle while armed
//   i_post_count        strobes captured after the trigger, 0 runs until abort/overflow
//   i_s                 synchronized channel data
//   i_sample_strobe     sampler strobe, already gated by o_sampler_enable
//   i_pipeline_busy     serializer/compressor still emitting
//   i_overflow          sampler output overflow
//   o_sampler_enable    strober enable
//   o_sampler_clear     one-cycle pipeline/timer clear
//   o_state             FSM state code
//   o_triggered, o_done, o_ovf_stop   sticky run status flags
//   o_sample_count      strobes counted since the trigger
module sampler_capture_ctrl #(
    parameter int W     = 16,
    parameter int CNT_W = 32,
    parameter int DRAIN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [W-1:0]     i_trig_mask,
    input  logic [W-1:0]     i_trig_value,
    input  logic [CNT_W-1:0] i_post_count,
    input  logic [W-1:0]     i_s,
    input  logic             i_sample_strobe,
    input  logic             i_pipeline_busy,
    input  logic             i_overflow,
    output logic             o_sampler_enable,
    output logic             o_sampler_clear,
    output logic [2:0]       o_state,
    output logic             o_triggered,
    output logic             o_done,
    output logic             o_ovf_stop,
    output logic [CNT_W-1:0] o_sample_count
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_ARMED   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DRAIN   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam int IW = $clog2(DRAIN + 1);

    state_t           r_state;
    logic             r_en;
    logic             r_clr;
    logic             r_trig;
    logic             r_done;
    logic             r_ovf;
    logic [CNT_W-1:0] r_count;
    logic [IW-1:0]    r_idle;
    logic             w_match;
    logic             w_last;

    assign w_match = ((i_s ^ i_trig_value) & i_trig_mask) == '0;
    // the strobe that brings the count up to post_count ends the capture on the same edge
    assign w_last  = i_sample_strobe && (i_post_count != '0) && (r_count == i_post_count - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_en    <= 1'b0;
            r_clr   <= 1'b0;
            r_trig  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_count <= '0;
            r_idle  <= '0;
        end else begin
            r_clr <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (!i_abort && i_start) begin
                        r_state <= S_CLEAR;
                        r_clr   <= 1'b1;
                        r_trig  <= 1'b0;
                        r_done  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_count <= '0;
                    end
                end
                S_CLEAR: r_state <= i_abort ? S_IDLE : S_ARMED;
                S_ARMED: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                    end else if (w_match) begin
                        r_state <= S_CAPTURE;
                        r_trig  <= 1'b1;
                        r_en    <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    // a strobe arriving with abort/overflow was already taken by the strober, so it still counts
                    if (i_sample_strobe) r_count <= r_count + CNT_W'(1);
                    r_idle <= '0;
                    if (i_abort || i_overflow || w_last) begin
                        r_state <= S_DRAIN;
                        r_en    <= 1'b0;
                    end
                    if (!i_abort && i_overflow) r_ovf <= 1'b1;
                end
                S_DRAIN: begin
                    r_idle <= i_pipeline_busy ? '0 : r_idle + IW'(1);
                    if (!i_pipeline_busy && r_idle == IW'(DRAIN - 1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_en    <= 1'b0;
                end
            endcase
        end
    end

    assign o_sampler_enable = r_en;
    assign o_sampler_clear  = r_clr;
    assign o_state          = r_state;
    assign o_triggered      = r_trig;
    assign o_done           = r_done;
    assign o_ovf_stop       = r_ovf;
    assign o_sample_count   = r_count;
endmodule

// File: tb/tb_sampler_capture_ctrl.sv
// tb_sampler_capture_ctrl: randomized runs with expected run results queued by the driver and checked by a monitor
module tb_sampler_capture_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] mask = '0;
    logic [15:0] value = '0;
    logic [31:0] post = '0;
    logic [15:0] s = '0;
    logic        strobe = 1'b0;
    logic        busy = 1'b0;
    logic        ovf = 1'b0;
    logic        en, clr, trig, done, ovfs;
    logic [2:0]  st;
    logic [31:0] cnt;

    sampler_capture_ctrl #(.W(16), .CNT_W(32), .DRAIN(4)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
        .i_trig_mask(mask), .i_trig_value(value), .i_post_count(post),
        .i_s(s), .i_sample_strobe(strobe), .i_pipeline_busy(busy), .i_overflow(ovf),
        .o_sampler_enable(en), .o_sampler_clear(clr), .o_state(st),
        .o_triggered(trig), .o_done(done), .o_ovf_stop(ovfs), .o_sample_count(cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int trig;
        int done;
        int ovf;
        int count;
        int clears;
        int armed;
        int drain;
        int endst;
    } exp_t;

    exp_t q[$];
    int   bl[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
        end
    endtask

    int          m_clr = 0;
    int          m_armed = 0;
    int          m_drain = 0;
    logic [2:0]  pst = '0;
    logic        pdone = 1'b0;
    exp_t        me;

    always @(negedge clk) begin
        if (rst) begin
            m_clr = 0;
            m_armed = 0;
            m_drain = 0;
        end else begin
            chk("enable_only_in_capture", en, st == 3'd3);
            chk("clear_only_in_clear", clr, st == 3'd1);
            chk("triggered_after_match", trig, st >= 3'd3 && st <= 3'd5);
            chk("done_only_in_done", done, st == 3'd5);
            if (clr) m_clr++;
            if (st == 3'd2) m_armed++;
            if (st == 3'd4) m_drain++;
            if ((done && !pdone) || (pst != 3'd0 && st == 3'd0)) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL run_end unexpected state=%0d", st);
                end else begin
                    me = q.pop_front();
                    chk("run_triggered", trig, me.trig);
                    chk("run_done", done, me.done);
                    chk("run_ovf_stop", ovfs, me.ovf);
                    chk("run_count", cnt, me.count);
                    chk("run_clear_pulses", m_clr, me.clears);
                    chk("run_armed_cycles", m_armed, me.armed);
                    chk("run_drain_cycles", m_drain, me.drain);
                    chk("run_end_state", st, me.endst);
                end
                m_clr = 0;
                m_armed = 0;
                m_drain = 0;
            end
        end
        pst = st;
        pdone = done;
    end

    // mode 0: count limit, 1: abort after n strobes, 2: overflow on strobe n, 3: abort in ARMED after n cycles
    task automatic run(input logic [15:0] m, input logic [15:0] v, input logic [31:0] p,
                       input int mode, input int n, input int d);
        exp_t        e;
        int          ns = 0;
        int          ac = 0;
        int          bi = 0;
        int          streak = 0;
        int          guard = 0;
        int          dd;
        logic [15:0] x;
        dd = (m == 16'h0) ? 0 : d;
        mask = m;
        value = v;
        post = p;
        e.trig = (mode != 3) ? 1 : 0;
        e.done = e.trig;
        e.ovf = (mode == 2) ? 1 : 0;
        e.count = (mode == 0) ? p : ((mode == 3) ? 0 : n);
        e.clears = 1;
        e.armed = (mode == 3) ? n + 1 : dd + 1;
        e.drain = 0;
        e.endst = (mode == 3) ? 0 : 5;
        if (mode != 3) begin
            for (int i = 0; i < bl.size() + 4; i++) begin
                streak = (i < bl.size() && bl[i] != 0) ? 0 : streak + 1;
                if (streak == 4) begin
                    e.drain = i + 1;
                    break;
                end
            end
        end
        q.push_back(e);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (guard < 5000) begin
            @(negedge clk);
            guard++;
            strobe = 1'b0;
            abort = 1'b0;
            ovf = 1'b0;
            busy = 1'b0;
            if (st == 3'd5 || (st == 3'd0 && ac > 0)) break;
            if (st == 3'd2) begin
                x = 16'($urandom);
                if (((x ^ v) & m) == 16'h0) x = x ^ (m & (~m + 16'h1));
                if (mode == 3 && ac == n) abort = 1'b1;
                s = (mode != 3 && ac >= dd) ? ((x & ~m) | (v & m)) : x;
                ac++;
            end else if (st == 3'd3) begin
                if (mode == 1 && ns == n) begin
                    abort = 1'b1;
                end else if ($urandom_range(1) == 1) begin
                    strobe = 1'b1;
                    ns++;
                    if (mode == 2 && ns == n) ovf = 1'b1;
                end
            end else if (st == 3'd4) begin
                busy = (bi < bl.size()) ? (bl[bi] != 0) : 1'b0;
                bi++;
            end
        end
        if (guard >= 5000) begin
            total++;
            bad++;
            $display("FAIL run_timeout state=%0d mode=%0d", st, mode);
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            q.delete();
        end
    endtask

    initial begin
        int          g;
        int          mode;
        int          n;
        int          len;
        logic [15:0] m;
        logic [31:0] p;
        repeat (3) @(negedge clk);
        chk("por_state", st, 3'd0);
        chk("por_enable", en, 1'b0);
        chk("por_clear", clr, 1'b0);
        chk("por_triggered", trig, 1'b0);
        chk("por_done", done, 1'b0);
        chk("por_ovf_stop", ovfs, 1'b0);
        chk("por_count", cnt, 32'd0);
        rst = 1'b0;
        bl = '{};
        run(16'h00FF, 16'h0042, 32'd5, 0, 0, 10);
        run(16'h0000, 16'h0000, 32'd0, 1, 100, 0);
        run(16'h00FF, 16'h0042, 32'd5, 3, 7, 0);
        run(16'hF000, 16'hA000, 32'd1000, 2, 37, 3);
        bl = '{1, 1, 1, 0, 0, 1, 0, 0, 0, 0};
        run(16'h0000, 16'h0000, 32'd3, 0, 0, 0);
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_in_done_state", st, 3'd5);
        chk("start_abort_in_done_flag", done, 1'b1);
        for (int r = 0; r < 24; r++) begin
            mode = int'($urandom_range(3));
            m = 16'($urandom);
            if ($urandom_range(3) == 0) m = 16'h0;
            if (mode == 3 && m == 16'h0) m = 16'h0001;
            p = ($urandom_range(4) == 0) ? 32'd0 : 32'($urandom_range(30, 1));
            n = (p == 0) ? int'($urandom_range(40, 1)) : int'($urandom_range(p, 1));
            if (mode == 1 && p != 0) n = n - 1;
            if (mode == 3) n = int'($urandom_range(5));
            if (mode == 0 && p == 0) p = 32'd7;
            len = int'($urandom_range(6));
            bl = '{};
            for (int i = 0; i < len; i++) bl.push_back(int'($urandom_range(1)));
            run(m, 16'($urandom), p, mode, n, int'($urandom_range(8)));
        end
        bl = '{};
        mask = 16'h0;
        post = 32'd0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        g = 0;
        while (st != 3'd3 && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("mid_capture_reached", st, 3'd3);
        repeat (3) begin
            strobe = (st == 3'd3);
            @(negedge clk);
        end
        strobe = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_state", st, 3'd0);
        chk("rst_enable", en, 1'b0);
        chk("rst_clear", clr, 1'b0);
        chk("rst_triggered", trig, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ovf_stop", ovfs, 1'b0);
        chk("rst_count", cnt, 32'd0);
        chk("queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
